// File: rtl/servo_ramp_sequencer.sv
// Command-driven slew sequencer feeding the 4-channel servo PWM stage.
// Optional build macro SERVO_SOFTLIMIT_EN clamps move codes to [LIM_LO, LIM_HI].
module servo_ramp_sequencer #(
  parameter int TICK_DIV    = 1_000_000,
  parameter int ONTIME_MIN  = 50_000,
  parameter int ONTIME_STEP = 3_333,
  parameter int RAMP_STEP   = 1_000,
  parameter int LIM_LO      = 0,
  parameter int LIM_HI      = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_ch,
  input  logic         cmd_op,
  input  logic [3:0]   cmd_angle,
  output logic [111:0] ontime,
  output logic [3:0]   ontime_load,
  output logic [3:0]   enable,
  output logic [3:0]   busy,
  output logic         frame_tick
);

  localparam int DATA_W = 28;
  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DATA_W-1:0] CENTRE  = DATA_W'(ONTIME_MIN + 8 * ONTIME_STEP);
  localparam logic [DATA_W-1:0] STEP_MX = DATA_W'(RAMP_STEP);

`ifdef SERVO_SOFTLIMIT_EN
  localparam bit SOFTLIMIT = 1'b1;
`else
  localparam bit SOFTLIMIT = 1'b0;
`endif
  localparam logic [3:0] CODE_LO = SOFTLIMIT ? 4'(LIM_LO) : 4'd0;
  localparam logic [3:0] CODE_HI = SOFTLIMIT ? 4'(LIM_HI) : 4'd15;

  typedef enum logic [2:0] {IDLE, SCAN0, SCAN1, SCAN2, SCAN3} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  frame_cnt;
  logic [DATA_W-1:0] cur [4];
  logic [DATA_W-1:0] tgt [4];
  logic              init_flag;
  logic              accept;
  logic              scan_act;
  logic [1:0]        scan_ch;
  logic [DATA_W-1:0] slew_val;

  function automatic logic [3:0] clamp_code(input logic [3:0] code);
    if (code < CODE_LO) return CODE_LO;
    if (code > CODE_HI) return CODE_HI;
    return code;
  endfunction

  function automatic logic [DATA_W-1:0] code_to_ontime(input logic [3:0] code);
    return DATA_W'(ONTIME_MIN) + DATA_W'(code) * DATA_W'(ONTIME_STEP);
  endfunction

  // Bounded step toward the target; the final step lands exactly on it.
  function automatic logic [DATA_W-1:0] slew(input logic [DATA_W-1:0] c,
                                             input logic [DATA_W-1:0] t);
    if (c < t) return ((t - c) > STEP_MX) ? c + STEP_MX : t;
    if (c > t) return ((c - t) > STEP_MX) ? c - STEP_MX : t;
    return c;
  endfunction

  assign frame_tick = (frame_cnt == CNT_W'(TICK_DIV - 1));
  assign accept     = cmd_valid & cmd_ready;
  assign slew_val   = slew(cur[scan_ch], tgt[scan_ch]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= '0;
    else                 frame_cnt <= frame_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_tick) state_nxt = SCAN0;
      SCAN0:   state_nxt = SCAN1;
      SCAN1:   state_nxt = SCAN2;
      SCAN2:   state_nxt = SCAN3;
      SCAN3:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    scan_act  = 1'b0;
    scan_ch   = 2'd0;
    cmd_ready = rst_n & (state == IDLE) & ~frame_tick;
    case (state)
      SCAN0:   begin scan_act = 1'b1; scan_ch = 2'd0; end
      SCAN1:   begin scan_act = 1'b1; scan_ch = 2'd1; end
      SCAN2:   begin scan_act = 1'b1; scan_ch = 2'd2; end
      SCAN3:   begin scan_act = 1'b1; scan_ch = 2'd3; end
      default: ;
    endcase
  end

  // Commands only land in IDLE, so tgt is stable while a channel is scanned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cur[i] <= CENTRE;
        tgt[i] <= CENTRE;
      end
      enable    <= '0;
      init_flag <= 1'b1;
    end else begin
      if (accept) begin
        if (!cmd_op) begin
          tgt[cmd_ch]    <= code_to_ontime(clamp_code(cmd_angle));
          enable[cmd_ch] <= 1'b1;
        end else begin
          enable[cmd_ch] <= 1'b0;
        end
      end
      if (scan_act)        cur[scan_ch] <= slew_val;
      if (state == SCAN3)  init_flag    <= 1'b0;
    end
  end

  // The scanned channel shows its new value and strobe in the same cycle.
  always_comb begin
    ontime      = '0;
    ontime_load = '0;
    busy        = '0;
    for (int i = 0; i < 4; i++) begin
      busy[i] = (cur[i] != tgt[i]);
      if (scan_act && scan_ch == 2'(i)) begin
        ontime[i*DATA_W +: DATA_W] = slew_val;
        ontime_load[i]             = init_flag | (slew_val != cur[i]);
      end else begin
        ontime[i*DATA_W +: DATA_W] = cur[i];
      end
    end
  end

endmodule

// File: tb/tb_servo_ramp_sequencer.sv
// Bench for servo_ramp_sequencer: table-driven ramps, hand sequences and random
// commands, all checked every cycle against a frame-position reference model.
module tb_servo_ramp_sequencer;
  localparam int TD = 16, OMIN = 100, OSTEP = 10, RSTEP = 25, LLO = 0, LHI = 12;
  localparam int CTR = OMIN + 8 * OSTEP;

  logic         clk = 1'b0, rst_n = 1'b1;
  logic         cmd_valid = 1'b0, cmd_op = 1'b0;
  logic [1:0]   cmd_ch = 2'd0;
  logic [3:0]   cmd_angle = 4'd0;
  logic         cmd_ready, frame_tick;
  logic [111:0] ontime;
  logic [3:0]   ontime_load, enable, busy;

  int n_chk = 0, n_pass = 0;

  servo_ramp_sequencer #(.TICK_DIV(TD), .ONTIME_MIN(OMIN), .ONTIME_STEP(OSTEP),
                         .RAMP_STEP(RSTEP), .LIM_LO(LLO), .LIM_HI(LHI)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_op(cmd_op), .cmd_angle(cmd_angle), .ontime(ontime),
    .ontime_load(ontime_load), .enable(enable), .busy(busy), .frame_tick(frame_tick));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: channel state plus the cycle position inside the frame.
  int m_cur [4];
  int m_tgt [4];
  bit [3:0] m_en = '0;
  bit m_init = 1'b1;
  int cyc = 0;

  function automatic int slew_to(int c, int t);
    if (t > c) return (t - c > RSTEP) ? c + RSTEP : t;
    if (c > t) return (c - t > RSTEP) ? c - RSTEP : t;
    return c;
  endfunction

  function automatic int code_val(int code);
    int k;
    k = code;
`ifdef SERVO_SOFTLIMIT_EN
    if (k < LLO) k = LLO;
    if (k > LHI) k = LHI;
`endif
    return OMIN + k * OSTEP;
  endfunction

  function automatic bit in_scan(int c);
    return (c >= TD) && ((c % TD) < 4);
  endfunction

  function automatic bit exp_ready();
    return rst_n && ((cyc % TD) != TD - 1) && !in_scan(cyc);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit rdy;
    int p;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin m_cur[i] = CTR; m_tgt[i] = CTR; end
      m_en = '0; m_init = 1'b1; cyc = 0;
    end else begin
      rdy = exp_ready();
      p = cyc % TD;
      if (in_scan(cyc)) begin
        m_cur[p] = slew_to(m_cur[p], m_tgt[p]);
        if (p == 3) m_init = 1'b0;
      end
      if (cmd_valid && rdy) begin
        if (!cmd_op) begin m_tgt[cmd_ch] = code_val(int'(cmd_angle)); m_en[cmd_ch] = 1'b1; end
        else m_en[cmd_ch] = 1'b0;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin : monitor
    logic [111:0] e_on;
    logic [3:0] e_ld, e_busy;
    int p, nv;
    p = cyc % TD;
    e_ld = '0;
    for (int i = 0; i < 4; i++) begin
      e_on[i*28 +: 28] = 28'(m_cur[i]);
      e_busy[i] = (m_cur[i] != m_tgt[i]);
    end
    if (rst_n && in_scan(cyc)) begin
      nv = slew_to(m_cur[p], m_tgt[p]);
      e_on[p*28 +: 28] = 28'(nv);
      e_ld[p] = m_init || (nv != m_cur[p]);
    end
    chk("mon_ontime", ontime, e_on);
    chk("mon_load", ontime_load, e_ld);
    chk("mon_enable", enable, m_en);
    chk("mon_busy", busy, e_busy);
    chk("mon_tick", frame_tick, rst_n && (p == TD - 1));
    chk("mon_ready", cmd_ready, exp_ready());
  end

  task automatic wait_tick();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3 * TD; i++) begin
      if (frame_tick) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("frame_tick_wait", got, 1'b1);
  endtask

  task automatic send_cmd(input logic [1:0] ch, input logic op, input logic [3:0] code);
    bit done;
    done = 1'b0;
    cmd_ch = ch; cmd_op = op; cmd_angle = code; cmd_valid = 1'b1;
    for (int i = 0; i < 3 * TD && !done; i++) begin
      done = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("cmd_accept", done, 1'b1);
  endtask

  typedef struct {
    logic [1:0] ch;
    logic       op;
    logic [3:0] code;
    int         n;
    int         seq [8];
  } vec_t;

  vec_t vt [6];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int prev, n_low, ch;
`ifdef SERVO_SOFTLIMIT_EN
    vt[0] = '{ch:2'd1, op:1'b0, code:4'd15, n:4, seq:'{205, 220, 220, 220, 0, 0, 0, 0}};
    vt[1] = '{ch:2'd1, op:1'b0, code:4'd0,  n:7, seq:'{195, 170, 145, 120, 100, 100, 100, 0}};
`else
    vt[0] = '{ch:2'd1, op:1'b0, code:4'd15, n:4, seq:'{205, 230, 250, 250, 0, 0, 0, 0}};
    vt[1] = '{ch:2'd1, op:1'b0, code:4'd0,  n:7, seq:'{225, 200, 175, 150, 125, 100, 100, 0}};
`endif
    vt[2] = '{ch:2'd2, op:1'b0, code:4'd0,  n:4, seq:'{155, 130, 105, 100, 0, 0, 0, 0}};
    vt[3] = '{ch:2'd1, op:1'b1, code:4'd7,  n:2, seq:'{100, 100, 0, 0, 0, 0, 0, 0}};
    vt[4] = '{ch:2'd0, op:1'b0, code:4'd8,  n:2, seq:'{180, 180, 0, 0, 0, 0, 0, 0}};
    vt[5] = '{ch:2'd3, op:1'b0, code:4'd5,  n:3, seq:'{155, 150, 150, 0, 0, 0, 0, 0}};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ontime", ontime, {4{28'd180}});
    chk("rst_enable", enable, 4'd0);
    chk("rst_busy", busy, 4'd0);
    chk("rst_ready", cmd_ready, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    wait_tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("init_load", ontime_load, 4'b0001 << i);
      chk("init_value", ontime[i*28 +: 28], 28'd180);
    end
    @(negedge clk);
    wait_tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("frame2_noload", ontime_load, 4'd0);
    end

    for (int v = 0; v < 6; v++) begin
      ch = int'(vt[v].ch);
      prev = int'(ontime[ch*28 +: 28]);
      send_cmd(vt[v].ch, vt[v].op, vt[v].code);
      chk("vec_enable", enable[ch], !vt[v].op);
      for (int k = 0; k < vt[v].n; k++) begin
        wait_tick();
        repeat (ch + 1) @(negedge clk);
        chk("vec_ontime", ontime[ch*28 +: 28], 28'(vt[v].seq[k]));
        chk("vec_load", ontime_load, (vt[v].seq[k] != prev) ? (4'b0001 << ch) : 4'd0);
        prev = vt[v].seq[k];
      end
    end

    // Command held from the tick cycle is stalled through the tick and four scans.
    send_cmd(2'd2, 1'b0, 4'd15);
    wait_tick();
    cmd_ch = 2'd2; cmd_op = 1'b0; cmd_angle = 4'd12; cmd_valid = 1'b1;
    n_low = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready) break;
      n_low++;
      @(negedge clk);
    end
    chk("hold_ready_low", n_low, 5);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hold_busy", busy[2], 1'b1);
    repeat (5 * TD) @(negedge clk);
    chk("retarget_final", ontime[2*28 +: 28], 28'd220);
    chk("retarget_idle", busy[2], 1'b0);

    // Disable keeps the on-time; reset during SCAN2 restores everything at once.
    prev = int'(ontime[1*28 +: 28]);
    send_cmd(2'd3, 1'b1, 4'd0);
    chk("disable_enable", enable[3], 1'b0);
    chk("disable_hold", ontime[3*28 +: 28], 28'd150);
    wait_tick();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ontime", ontime, {4{28'd180}});
    chk("async_enable", enable, 4'd0);
    chk("async_load", ontime_load, 4'd0);
    chk("async_ready", cmd_ready, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 60; r++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send_cmd(2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
    end
    repeat (12 * TD) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
